// File: rtl/pic8259_lite.sv
// Simplified 8259-style interrupt controller: edge-latched requests, fully nested
// priority (IRQ0 highest), IMR/EOI/status access over a byte-wide I/O port.
//
//   state   | meaning
//   ST_IDLE | no vector presented; looking for an eligible request
//   ST_REQ  | vector presented to the cpu, held until irq_ack
module pic8259_lite #(
  parameter logic [7:0] VECTOR_BASE = 8'h08,
  parameter logic [7:0] IMR_RESET   = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic [1:0] io_address,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       irq_signal,
  output logic [7:0] irq_id,
  input  logic       irq_ack
);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_irq_prev;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic [2:0] r_n;
  logic [7:0] r_irq_id;
  logic [7:0] r_rdata;

  logic [7:0] w_edge;
  logic [7:0] w_pend;
  logic [3:0] w_pend_low;
  logic [3:0] w_isr_low;
  logic       w_eligible;
  logic       w_load;
  logic       w_take;
  logic       w_eoi;
  logic [7:0] w_take_bit;
  logic [7:0] w_isr_after_eoi;
  logic [7:0] w_irr_next;
  logic [7:0] w_isr_next;

  // Index of the lowest set bit; an all-zero vector reports 8 (below every priority).
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[3:0];
    end
  endfunction

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_pend     = r_irr & ~r_imr;
  assign w_pend_low = lowest_idx(w_pend);
  assign w_isr_low  = lowest_idx(r_isr);
  assign w_eligible = (w_pend_low < w_isr_low);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_state_next = ST_REQ;
          w_load       = 1'b1;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          w_state_next = ST_IDLE;
          w_take       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // EOI acts on the pre-cycle ISR so a bit acknowledged in the same cycle survives.
  assign w_eoi           = io_we && (io_address == 2'd0) && io_wdata[5];
  assign w_take_bit      = w_take ? (8'd1 << r_n) : 8'd0;
  assign w_isr_after_eoi = w_eoi ? (r_isr & ~(r_isr & (~r_isr + 8'd1))) : r_isr;
  assign w_isr_next      = w_isr_after_eoi | w_take_bit;
  assign w_irr_next      = (r_irr & ~w_take_bit) | w_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq_prev <= 8'h00;
      r_irr      <= 8'h00;
      r_isr      <= 8'h00;
      r_imr      <= IMR_RESET;
      r_n        <= 3'd0;
      r_irq_id   <= 8'h00;
      r_rdata    <= 8'h00;
    end else begin
      r_irq_prev <= irq_in;
      r_irr      <= w_irr_next;
      r_isr      <= w_isr_next;
      if (io_we && (io_address == 2'd1)) r_imr <= io_wdata;
      if (w_load) begin
        r_n      <= w_pend_low[2:0];
        r_irq_id <= VECTOR_BASE + {5'd0, w_pend_low[2:0]};
      end
      case (io_address)
        2'd0:    r_rdata <= r_isr;
        2'd1:    r_rdata <= r_imr;
        2'd2:    r_rdata <= r_irr;
        default: r_rdata <= 8'h00;
      endcase
    end
  end

  assign irq_signal = (r_state == ST_REQ);
  assign irq_id     = r_irq_id;
  assign io_rdata   = r_rdata;

endmodule

// File: tb/tb_pic8259_lite.sv
// Directed bench for pic8259_lite: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_pic8259_lite;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic [1:0] io_address;
  logic       io_we;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       irq_signal;
  logic [7:0] irq_id;
  logic       irq_ack;

  int n_cmp = 0;
  int n_err = 0;

  pic8259_lite #(.VECTOR_BASE(8'h08), .IMR_RESET(8'hFF)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .io_address (io_address),
    .io_we      (io_we),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .irq_signal (irq_signal),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    io_address = a;
    tick();
    chk(tag, io_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_address = a;
    io_wdata   = d;
    io_we      = 1'b1;
    tick();
    io_we      = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq_in = lines;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 8'h00; io_address = 2'd0; io_we = 1'b0;
    io_wdata = 8'h00; irq_ack = 1'b0;
    #1;
    chk("rst_sig", {7'd0, irq_signal}, 8'h00);
    chk("rst_id", irq_id, 8'h00);
    chk("rst_rdata", io_rdata, 8'h00);
    tick(); tick();
    reset = 1'b0;

    rd("imr_reset", 2'd1, 8'hFF);
    pulse(8'h08);
    rd("irr_masked", 2'd2, 8'h08);
    tick();
    chk("masked_no_sig", {7'd0, irq_signal}, 8'h00);

    // New mask is not seen by the eligibility check in the writing cycle.
    wr(2'd1, 8'h00);
    chk("imr_old_used", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq3_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq3_id", irq_id, 8'h0B);
    ack();
    chk("irq3_ack_sig", {7'd0, irq_signal}, 8'h00);
    rd("isr_08", 2'd0, 8'h08);
    rd("irr_00", 2'd2, 8'h00);
    ack();
    rd("idle_ack_ignored", 2'd0, 8'h08);

    pulse(8'h20);
    tick();
    chk("irq5_blocked", {7'd0, irq_signal}, 8'h00);
    pulse(8'h02);
    chk("irq1_latency", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq1_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq1_id", irq_id, 8'h09);
    ack();
    chk("irq1_ack_sig", {7'd0, irq_signal}, 8'h00);
    wr(2'd0, 8'h20);
    chk("rdata_latency", io_rdata, 8'h0A);
    tick();
    chk("eoi1_isr", io_rdata, 8'h08);
    wr(2'd0, 8'h20);
    chk("eoi2_no_sig", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq5_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq5_id", irq_id, 8'h0D);
    chk("eoi2_isr", io_rdata, 8'h00);

    // EOI with an empty ISR in the same cycle as the ack leaves the acked bit set.
    irq_ack = 1'b1;
    wr(2'd0, 8'h20);
    irq_ack = 1'b0;
    tick();
    chk("ack_eoi_isr", io_rdata, 8'h20);
    wr(2'd0, 8'h10);
    tick();
    chk("non_eoi_ignored", io_rdata, 8'h20);
    wr(2'd0, 8'h20);
    tick();
    chk("eoi5_isr", io_rdata, 8'h00);

    pulse(8'h44);
    chk("irq26_latency", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq2_id", irq_id, 8'h0A);
    ack();
    wr(2'd0, 8'h20);
    chk("irq6_wait", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq6_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq6_id", irq_id, 8'h0E);

    wr(2'd1, 8'hFF);
    chk("req_mask_hold", {7'd0, irq_signal}, 8'h01);
    pulse(8'h01);
    tick();
    chk("req_hold_id", irq_id, 8'h0E);
    wr(2'd1, 8'h00);
    chk("req_hold_id2", irq_id, 8'h0E);
    ack();
    chk("irq6_ack_sig", {7'd0, irq_signal}, 8'h00);
    tick();
    chk("irq0_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq0_id", irq_id, 8'h08);

    // Ack and a fresh edge on the same line: the request stays pending.
    irq_in  = 8'h01;
    irq_ack = 1'b1;
    tick();
    irq_in  = 8'h00;
    irq_ack = 1'b0;
    chk("ack_edge_sig", {7'd0, irq_signal}, 8'h00);
    rd("ack_edge_irr", 2'd2, 8'h01);
    rd("ack_edge_isr", 2'd0, 8'h41);
    wr(2'd0, 8'h20);
    tick();
    chk("irq0_again_sig", {7'd0, irq_signal}, 8'h01);
    chk("irq0_again_id", irq_id, 8'h08);

    #2 reset = 1'b1;
    #1;
    chk("async_rst_sig", {7'd0, irq_signal}, 8'h00);
    chk("async_rst_id", irq_id, 8'h00);
    tick(); tick();
    reset = 1'b0;
    rd("post_rst_irr", 2'd2, 8'h00);
    rd("post_rst_isr", 2'd0, 8'h00);
    rd("post_rst_imr", 2'd1, 8'hFF);
    chk("post_rst_sig", {7'd0, irq_signal}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
